csel_addsub_pipe: RTL

//  Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake.
//  - Generalises the team's 8-bit ripple-select add/sub to WIDTH bits.
//  - Splits the datapath into BLOCK-bit carry-select segments.
//  - Adds registered flags and back-pressure.
//  - Sits between operand producers (register file / ALU front end) and a result consumer.

---
 rtl/csel_addsub_pipe_if.sv | 35 +++
 rtl/csel_addsub_pipe.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/csel_addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// csel_addsub_pipe_if
// Operand/result handshake bundle for csel_addsub_pipe.
//   master : operand producer / result consumer side (drives operands, out_ready)
//   slave  : the adder/subtractor pipeline (drives in_ready and the result beat)
// Signals:
//   in_valid, in_ready, a, b, sub      operand beat (valid/ready)
//   out_valid, out_ready, sum,
//   carry_out, overflow, zero          result beat (valid/ready)
// ----------------------------------------------------------------------------
interface csel_addsub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow, zero
   );
endinterface

// File: rtl/csel_addsub_pipe.sv
// ----------------------------------------------------------------------------
// csel_addsub_pipe
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow
// control on both sides.
//   S1 : registers a, b ^ {WIDTH{sub}} and sub.
//   S2 : computes the carry-select sum and flags, registers them as the output.
// Latency: a beat accepted on one edge is presented after the following edge.
// Throughput: one beat per cycle while out_ready is high.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; in_ready rises on the first edge
//          after release
//   bus    csel_addsub_pipe_if.slave (operand in, result out)
// Parameters:
//   WIDTH  operand/result width, a multiple of BLOCK, >= 2
//   BLOCK  carry-select segment width
// Build option:
//   SATURATE_EN  when defined, an overflowing result is clamped to the most
//                positive/negative value; carry_out and overflow stay raw.
// ----------------------------------------------------------------------------
module csel_addsub_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   csel_addsub_pipe_if.slave  bus
);
   localparam int NSEG = WIDTH / BLOCK;

   // Flow control
   logic ready_en;     // low from reset until the first edge after release
   logic s1_valid;
   logic s2_valid;
   logic adv1;
   logic adv2;
   logic accept;

   // Stage 1 state
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_bi;
   logic             s1_sub;

   // Stage 2 (output) state
   logic [WIDTH-1:0] s2_sum;
   logic             s2_carry;
   logic             s2_ovf;
   logic             s2_zero;

   // Stage 2 combinational datapath
   logic [WIDTH-1:0] sum_raw;
   logic             carry_raw;
   logic             ovf_raw;
   logic [WIDTH-1:0] sum_final;
   logic [BLOCK:0]   seg_lo;
   logic [BLOCK:0]   seg_c0;
   logic [BLOCK:0]   seg_c1;
   logic             seg_carry;

   // A stage may advance when it is empty or its downstream slot frees up
   // this cycle; in_ready therefore follows out_ready combinationally.
   assign adv2         = !s2_valid || bus.out_ready;
   assign adv1         = !s1_valid || adv2;
   assign bus.in_ready = adv1 && ready_en;
   assign accept       = bus.in_valid && bus.in_ready;

   // Carry-select adder: segment 0 ripples from cin, every higher segment
   // computes both carry-in outcomes and the incoming carry picks one.
   // NOTE: every variable gets a default before any conditional logic so the
   // block stays purely combinational (no latches).
   always_comb begin
      sum_raw   = '0;
      seg_c0    = '0;
      seg_c1    = '0;
      seg_lo    = {1'b0, s1_a[BLOCK-1:0]} + {1'b0, s1_bi[BLOCK-1:0]}
                + {{BLOCK{1'b0}}, s1_sub};
      sum_raw[BLOCK-1:0] = seg_lo[BLOCK-1:0];
      seg_carry = seg_lo[BLOCK];
      for (int k = 1; k < NSEG; k++) begin
         seg_c0 = {1'b0, s1_a[k*BLOCK +: BLOCK]} + {1'b0, s1_bi[k*BLOCK +: BLOCK]};
         seg_c1 = {1'b0, s1_a[k*BLOCK +: BLOCK]} + {1'b0, s1_bi[k*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};
         sum_raw[k*BLOCK +: BLOCK] = seg_carry ? seg_c1[BLOCK-1:0] : seg_c0[BLOCK-1:0];
         seg_carry                 = seg_carry ? seg_c1[BLOCK]     : seg_c0[BLOCK];
      end
      carry_raw = seg_carry;
   end

   // Signed overflow: both addends share a sign that the result does not.
   assign ovf_raw = (s1_a[WIDTH-1] == s1_bi[WIDTH-1]) && (sum_raw[WIDTH-1] != s1_a[WIDTH-1]);

`ifdef SATURATE_EN
   // Overflow direction follows the sign of a (equal to the sign of bi).
   assign sum_final = !ovf_raw      ? sum_raw :
                      s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign sum_final = sum_raw;
`endif

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others.
   // NOTE: data registers are reset too, because the result is visible on the
   // port and must read zero during and right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_bi    <= '0;
         s1_sub   <= 1'b0;
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_carry <= 1'b0;
         s2_ovf   <= 1'b0;
         s2_zero  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (adv1) begin
            s1_valid <= accept;
         end
         if (accept) begin
            s1_a   <= bus.a;
            s1_bi  <= bus.b ^ {WIDTH{bus.sub}};
            s1_sub <= bus.sub;
         end
         if (adv2) begin
            s2_valid <= s1_valid;
         end
         // The output only changes when a real beat moves in, so a stalled
         // result stays stable.
         if (adv2 && s1_valid) begin
            s2_sum   <= sum_final;
            s2_carry <= carry_raw;
            s2_ovf   <= ovf_raw;
            s2_zero  <= (sum_final == '0);
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.sum       = s2_sum;
   assign bus.carry_out = s2_carry;
   assign bus.overflow  = s2_ovf;
   assign bus.zero      = s2_zero;

endmodule
